adc_scan_sequencer: RTL and testbench

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_scan_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// Round-robin scan of up to four ADC inputs over an I2C master: configure,
// wait for the single-shot conversion, set the pointer, read, publish.
module adc_scan_sequencer #(
    parameter logic [6:0] SLAVE_ADDR       = 7'h48,
    parameter int         CONV_WAIT_CYCLES = 500000,
    parameter int         TIMEOUT_CYCLES   = 1000000,
    parameter int         MAX_RETRIES      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  ch_mask,
    output logic        i2c_start,
    output logic        i2c_rd_nwr,
    output logic [6:0]  i2c_slave_addr,
    output logic [23:0] i2c_din,
    output logic [1:0]  i2c_bytes_num,
    input  logic [15:0] i2c_dout,
    input  logic        i2c_done,
    input  logic        i2c_error,
    output logic        sample_valid,
    output logic [1:0]  sample_ch,
    output logic [15:0] sample_data,
    output logic [3:0]  ch_fault,
    output logic        busy
);

    localparam int CNT_MAX = (CONV_WAIT_CYCLES > TIMEOUT_CYCLES) ? CONV_WAIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    typedef enum logic [3:0] {
        IDLE, SELECT, CFG_START, CFG_WAIT, CONV_WAIT,
        PTR_START, PTR_WAIT, RD_START, RD_WAIT, PUBLISH
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [1:0]         ch_q, ch_d;
    logic [1:0]         last_ch_q, last_ch_d;
    logic               last_vld_q, last_vld_d;
    logic               rd_nwr_q, rd_nwr_d;
    logic [23:0]        din_q, din_d;
    logic [1:0]         bytes_q, bytes_d;
    logic [1:0]         sample_ch_q, sample_ch_d;
    logic [15:0]        sample_data_q, sample_data_d;
    logic [3:0]         fault_q, fault_d;

    logic               ok, fail, expired;
    state_e             next_scan;

    // First set mask bit at or after 'from', wrapping 3 -> 0.
    function automatic logic [1:0] pick_ch(input logic [3:0] mask, input logic [1:0] from);
        logic [1:0] idx;
        logic [1:0] res;
        res = from;
        for (int k = 3; k >= 0; k--) begin
            idx = from + 2'(k);
            if (mask[idx]) res = idx;
        end
        return res;
    endfunction

    function automatic state_e start_of(input state_e s);
        case (s)
            CFG_WAIT: return CFG_START;
            PTR_WAIT: return PTR_START;
            default:  return RD_START;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            retry_q       <= '0;
            ch_q          <= '0;
            last_ch_q     <= '0;
            last_vld_q    <= 1'b0;
            rd_nwr_q      <= 1'b0;
            din_q         <= '0;
            bytes_q       <= '0;
            sample_ch_q   <= '0;
            sample_data_q <= '0;
            fault_q       <= '0;
        end else begin
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            ch_q          <= ch_d;
            last_ch_q     <= last_ch_d;
            last_vld_q    <= last_vld_d;
            rd_nwr_q      <= rd_nwr_d;
            din_q         <= din_d;
            bytes_q       <= bytes_d;
            sample_ch_q   <= sample_ch_d;
            sample_data_q <= sample_data_d;
            fault_q       <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        retry_d       = retry_q;
        ch_d          = ch_q;
        last_ch_d     = last_ch_q;
        last_vld_d    = last_vld_q;
        rd_nwr_d      = rd_nwr_q;
        din_d         = din_q;
        bytes_d       = bytes_q;
        sample_ch_d   = sample_ch_q;
        sample_data_d = sample_data_q;
        fault_d       = fault_q;

        // cnt holds cycles since the start pulse, so a retry starts TIMEOUT_CYCLES after the last one.
        expired   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        ok        = i2c_done && !i2c_error;
        fail      = (i2c_done && i2c_error) || (!i2c_done && expired);
        next_scan = (enable && (ch_mask != 4'b0000)) ? SELECT : IDLE;

        case (state_q)
            IDLE: begin
                if (enable && (ch_mask != 4'b0000)) state_d = SELECT;
            end
            SELECT: begin
                if (ch_mask != 4'b0000) begin
                    ch_d       = pick_ch(ch_mask, last_vld_q ? last_ch_q + 2'd1 : 2'd0);
                    last_ch_d  = ch_d;
                    last_vld_d = 1'b1;
                    retry_d    = '0;
                    state_d    = CFG_START;
                end else begin
                    state_d = IDLE;
                end
            end
            CFG_START: begin
                cnt_d   = CNT_W'(1);
                state_d = CFG_WAIT;
            end
            PTR_START: begin
                cnt_d   = CNT_W'(1);
                state_d = PTR_WAIT;
            end
            RD_START: begin
                cnt_d   = CNT_W'(1);
                state_d = RD_WAIT;
            end
            CFG_WAIT, PTR_WAIT, RD_WAIT: begin
                if (ok) begin
                    retry_d = '0;
                    cnt_d   = '0;
                    if (state_q == CFG_WAIT) begin
                        state_d = CONV_WAIT;
                    end else if (state_q == PTR_WAIT) begin
                        state_d = RD_START;
                    end else begin
                        sample_data_d  = i2c_dout;
                        sample_ch_d    = ch_q;
                        fault_d[ch_q]  = 1'b0;
                        state_d        = PUBLISH;
                    end
                end else if (fail) begin
                    if (retry_q == RTY_W'(MAX_RETRIES)) begin
                        fault_d[ch_q] = 1'b1;
                        retry_d       = '0;
                        state_d       = next_scan;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = start_of(state_q);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CONV_WAIT: begin
                if (cnt_q == CNT_W'(CONV_WAIT_CYCLES - 1)) state_d = PTR_START;
                else cnt_d = cnt_q + 1'b1;
            end
            PUBLISH: begin
                state_d = next_scan;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Transaction fields are loaded on entry to a start state and held through the wait.
        if (state_d != state_q) begin
            case (state_d)
                CFG_START: begin
                    rd_nwr_d = 1'b0;
                    bytes_d  = 2'd3;
                    din_d    = {8'h01, 8'hC3 | {2'b00, ch_d, 4'b0000}, 8'h83};
                end
                PTR_START: begin
                    rd_nwr_d = 1'b0;
                    bytes_d  = 2'd1;
                    din_d    = 24'h000000;
                end
                RD_START: begin
                    rd_nwr_d = 1'b1;
                    bytes_d  = 2'd2;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        i2c_start      = (state_q == CFG_START) || (state_q == PTR_START) || (state_q == RD_START);
        sample_valid   = (state_q == PUBLISH);
        busy           = (state_q != IDLE);
        i2c_rd_nwr     = rd_nwr_q;
        i2c_slave_addr = SLAVE_ADDR;
        i2c_din        = din_q;
        i2c_bytes_num  = bytes_q;
        sample_ch      = sample_ch_q;
        sample_data    = sample_data_q;
        ch_fault       = fault_q;
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural I2C master model
// (fixed 3-cycle latency, optional NACK of channel-2 configs, optional silence).
module tb_adc_scan_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  ch_mask = 4'b0000;
    logic        i2c_start;
    logic        i2c_rd_nwr;
    logic [6:0]  i2c_slave_addr;
    logic [23:0] i2c_din;
    logic [1:0]  i2c_bytes_num;
    logic [15:0] i2c_dout = 16'h0000;
    logic        i2c_done = 1'b0;
    logic        i2c_error = 1'b0;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [15:0] sample_data;
    logic [3:0]  ch_fault;
    logic        busy;

    adc_scan_sequencer #(
        .SLAVE_ADDR(7'h48),
        .CONV_WAIT_CYCLES(10),
        .TIMEOUT_CYCLES(50),
        .MAX_RETRIES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .ch_mask(ch_mask),
        .i2c_start(i2c_start),
        .i2c_rd_nwr(i2c_rd_nwr),
        .i2c_slave_addr(i2c_slave_addr),
        .i2c_din(i2c_din),
        .i2c_bytes_num(i2c_bytes_num),
        .i2c_dout(i2c_dout),
        .i2c_done(i2c_done),
        .i2c_error(i2c_error),
        .sample_valid(sample_valid),
        .sample_ch(sample_ch),
        .sample_data(sample_data),
        .ch_fault(ch_fault),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // I2C master model and transaction log
    logic        nack_ch2   = 1'b0;
    logic        never_done = 1'b0;
    logic        pend_err   = 1'b0;
    int          lat_cnt    = 0;
    int          n_start    = 0;
    int          n_done     = 0;
    logic [23:0] log_din   [32];
    logic        log_rd    [32];
    logic [1:0]  log_bytes [32];
    int          log_start [32];
    int          log_done  [32];

    initial begin
        forever begin
            @(negedge clk);
            i2c_done  = 1'b0;
            i2c_error = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    i2c_done  = 1'b1;
                    i2c_error = pend_err;
                    if (n_done < 32) log_done[n_done] = cyc;
                    n_done++;
                end
            end
            if (i2c_start) begin
                chk("start_while_pending", (lat_cnt != 0) ? 32'd1 : 32'd0, 32'd0);
                if (n_start < 32) begin
                    log_din[n_start]   = i2c_din;
                    log_rd[n_start]    = i2c_rd_nwr;
                    log_bytes[n_start] = i2c_bytes_num;
                    log_start[n_start] = cyc;
                end
                n_start++;
                if (!never_done) begin
                    lat_cnt  = 3;
                    pend_err = nack_ch2 && !i2c_rd_nwr && (i2c_bytes_num == 2'd3) && (i2c_din[13:12] == 2'd2);
                end
            end
        end
    end

    // Sample monitor
    int          n_valid = 0;
    logic [1:0]  v_ch   [32];
    logic [15:0] v_data [32];
    int          v_cyc  [32];

    initial begin
        forever begin
            @(negedge clk);
            if (sample_valid) begin
                if (n_valid < 32) begin
                    v_ch[n_valid]   = sample_ch;
                    v_data[n_valid] = sample_data;
                    v_cyc[n_valid]  = cyc;
                end
                n_valid++;
            end
        end
    end

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        ch_mask = 4'b0000;
        repeat (3) @(negedge clk);
        lat_cnt    = 0;
        nack_ch2   = 1'b0;
        never_done = 1'b0;
        n_start    = 0;
        n_done     = 0;
        n_valid    = 0;
        reset      = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 1000 && busy; k++) @(negedge clk);
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_start",  {31'd0, i2c_start},     32'd0);
        chk("rst_rd",     {31'd0, i2c_rd_nwr},    32'd0);
        chk("rst_din",    {8'd0, i2c_din},        32'd0);
        chk("rst_bytes",  {30'd0, i2c_bytes_num}, 32'd0);
        chk("rst_sample", {13'd0, sample_valid, sample_ch, sample_data}, 32'd0);
        chk("rst_fault",  {28'd0, ch_fault},      32'd0);
        chk("rst_busy",   {31'd0, busy},          32'd0);
        chk("rst_addr",   {25'd0, i2c_slave_addr}, 32'h48);

        // Single channel, full transaction sequence
        do_reset();
        i2c_dout = 16'h1234;
        ch_mask  = 4'b0001;
        enable   = 1'b1;
        for (int k = 0; k < 500 && n_valid < 1; k++) @(negedge clk);
        enable = 1'b0;
        chk("t1_valid_seen", n_valid, 32'd1);
        chk("t1_cfg_din",    {8'd0, log_din[0]}, 32'h0001C383);
        chk("t1_cfg_wr",     {31'd0, log_rd[0]}, 32'd0);
        chk("t1_cfg_bytes",  {30'd0, log_bytes[0]}, 32'd3);
        // 10 CONV_WAIT cycles sit between the config-done cycle and the pointer start
        chk("t1_conv_gap",   log_start[1] - log_done[0], 32'd11);
        chk("t1_ptr_byte",   {24'd0, log_din[1][23:16]}, 32'h00);
        chk("t1_ptr_bytes",  {30'd0, log_bytes[1]}, 32'd1);
        chk("t1_ptr_wr",     {31'd0, log_rd[1]}, 32'd0);
        chk("t1_rd_rd",      {31'd0, log_rd[2]}, 32'd1);
        chk("t1_rd_bytes",   {30'd0, log_bytes[2]}, 32'd2);
        chk("t1_ch",         {30'd0, v_ch[0]}, 32'd0);
        chk("t1_data",       {16'd0, v_data[0]}, 32'h1234);
        chk("t1_valid_lat",  v_cyc[0] - log_done[2], 32'd1);
        wait_idle("t1_idle");
        chk("t1_one_sample", n_valid, 32'd1);

        // Round-robin over channels 1 and 3
        do_reset();
        ch_mask = 4'b1010;
        enable  = 1'b1;
        for (int k = 0; k < 1000 && n_valid < 3; k++) @(negedge clk);
        enable = 1'b0;
        chk("t2_valid_seen", (n_valid >= 3) ? 32'd1 : 32'd0, 32'd1);
        chk("t2_cfg0", {24'd0, log_din[0][15:8]}, 32'hD3);
        chk("t2_cfg1", {24'd0, log_din[3][15:8]}, 32'hF3);
        chk("t2_cfg2", {24'd0, log_din[6][15:8]}, 32'hD3);
        chk("t2_ch0",  {30'd0, v_ch[0]}, 32'd1);
        chk("t2_ch1",  {30'd0, v_ch[1]}, 32'd3);
        chk("t2_ch2",  {30'd0, v_ch[2]}, 32'd1);
        wait_idle("t2_idle");

        // Channel 2 config always NACKed -> fault after 4 attempts, then recovery
        do_reset();
        nack_ch2 = 1'b1;
        ch_mask  = 4'b0100;
        enable   = 1'b1;
        for (int k = 0; k < 500 && n_start < 4; k++) @(negedge clk);
        enable = 1'b0;
        wait_idle("t3_idle");
        chk("t3_attempts", n_start, 32'd4);
        chk("t3_fault",    {28'd0, ch_fault}, 32'b0100);
        chk("t3_no_valid", n_valid, 32'd0);
        nack_ch2 = 1'b0;
        enable   = 1'b1;
        for (int k = 0; k < 500 && n_valid < 1; k++) @(negedge clk);
        enable = 1'b0;
        wait_idle("t3_idle2");
        chk("t3_recover_valid", n_valid, 32'd1);
        chk("t3_recover_ch",    {30'd0, v_ch[0]}, 32'd2);
        chk("t3_fault_clear",   {28'd0, ch_fault}, 32'd0);

        // Silent slave -> retry every 50 cycles, fault after 4 attempts
        do_reset();
        never_done = 1'b1;
        ch_mask    = 4'b0001;
        enable     = 1'b1;
        for (int k = 0; k < 1000 && n_start < 4; k++) @(negedge clk);
        enable = 1'b0;
        wait_idle("t4_idle");
        chk("t4_attempts",  n_start, 32'd4);
        chk("t4_retry_gap", log_start[1] - log_start[0], 32'd50);
        chk("t4_fault",     {28'd0, ch_fault}, 32'b0001);
        chk("t4_no_valid",  n_valid, 32'd0);

        // enable dropped during CONV_WAIT: channel still completes
        do_reset();
        ch_mask = 4'b0001;
        enable  = 1'b1;
        for (int k = 0; k < 200 && n_done < 1; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        wait_idle("t5_idle");
        chk("t5_valid",  n_valid, 32'd1);
        chk("t5_starts", n_start, 32'd3);

        // Reset while the read is outstanding; the late done must be ignored
        do_reset();
        ch_mask = 4'b0001;
        enable  = 1'b1;
        for (int k = 0; k < 200 && n_start < 3; k++) @(negedge clk);
        @(negedge clk);
        chk("t6_in_rd_wait", {31'd0, busy}, 32'd1);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        chk("t6_rst_outs", {busy, i2c_start, i2c_rd_nwr, sample_valid, ch_fault, i2c_bytes_num, sample_ch, i2c_din[15:0]}, 32'd0);
        chk("t6_rst_din_hi", {24'd0, i2c_din[23:16]}, 32'd0);
        chk("t6_rst_data",   {16'd0, sample_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_late_done_seen", (n_done >= 3) ? 32'd1 : 32'd0, 32'd1);
        chk("t6_no_valid", n_valid, 32'd0);
        chk("t6_idle",     {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
